// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I definitions used by the PC generator, the fetch
// queue and the decoder.
// Contents: datapath width, the canonical NOP encoding, the major opcodes,
// and a helper function that extracts the opcode field.
package rv32i_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic [6:0] opcode_of(input logic [31:0] inst);
    return inst[6:0];
  endfunction

endpackage

// File: rtl/if_ring_buf.sv
// if_ring_buf: storage for the fetch queue. It holds a PC/instruction pair per
// entry, a per-entry "instruction returned" bit, and the head, alloc and fill
// pointers. All occupancy and drop bookkeeping lives in the parent.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               rewind all pointers and clear the filled bits
//   push, push_pc       allocate the entry at alloc with its fetch PC
//   fill_en, fill_inst  write a returned instruction at fill
//   pop                 retire the head entry
//   head_pc, head_inst  contents of the head entry
//   head_filled         head entry has its instruction
//   alloc_ptr, fill_ptr current pointer values, used to derive in-flight count
//   fill_slot_filled    filled bit of the entry fill points at
module if_ring_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [XLEN-1:0]            push_pc,
  input  logic                       fill_en,
  input  logic [XLEN-1:0]            fill_inst,
  input  logic                       pop,
  output logic [XLEN-1:0]            head_pc,
  output logic [XLEN-1:0]            head_inst,
  output logic                       head_filled,
  output logic [$clog2(DEPTH)-1:0]   alloc_ptr,
  output logic [$clog2(DEPTH)-1:0]   fill_ptr,
  output logic                       fill_slot_filled
);

  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0]  pc_mem_q   [DEPTH];
  logic [XLEN-1:0]  inst_mem_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    alloc_q;
  logic [PW-1:0]    fill_q;

  // Pointers wrap naturally because DEPTH is a power of two. The parent never
  // lets push/fill/pop target the same entry in one cycle, so the separate
  // writes to filled_q never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      alloc_q  <= '0;
      fill_q   <= '0;
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (flush) begin
      head_q   <= '0;
      alloc_q  <= '0;
      fill_q   <= '0;
      filled_q <= '0;
    end else begin
      if (push) begin
        pc_mem_q[alloc_q] <= push_pc;
        filled_q[alloc_q] <= 1'b0;
        alloc_q           <= alloc_q + 1'b1;
      end
      if (fill_en) begin
        inst_mem_q[fill_q] <= fill_inst;
        filled_q[fill_q]   <= 1'b1;
        fill_q             <= fill_q + 1'b1;
      end
      if (pop) begin
        filled_q[head_q] <= 1'b0;
        head_q           <= head_q + 1'b1;
      end
    end
  end

  assign head_pc          = pc_mem_q[head_q];
  assign head_inst        = inst_mem_q[head_q];
  assign head_filled      = filled_q[head_q];
  assign alloc_ptr        = alloc_q;
  assign fill_ptr         = fill_q;
  assign fill_slot_filled = filled_q[fill_q];

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch stage between the PC generator and the
// IF/ID register. It issues in-order requests to instruction memory, buffers
// returned instructions with their PCs, and hands them to decode with
// backpressure. A flush discards queued entries and arranges for responses
// still in flight to be dropped when they return.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   pc_in, pc_valid, pc_ready         fetch address handshake with the PC block
//   imem_req_valid/addr/ready         request channel to instruction memory
//   imem_resp_valid/data              in-order response channel
//   flush                             redirect, highest priority
//   id_ready                          decode can accept the head entry
//   if_valid, if_inst, if_pc          head entry presented to decode
module if_fetch_queue #(
  parameter int XLEN  = rv32i_pkg::XLEN,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_valid,
  output logic            pc_ready,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            flush,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc
);

  import rv32i_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] inflight;

  logic          issue;
  logic          push;
  logic          fill_en;
  logic          pop;
  logic          head_filled;
  logic          fill_slot_filled;
  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;

  // Issue is blocked while stale responses are still owed, so a dropped
  // response can never be mistaken for a fresh one.
  assign issue          = pc_valid && !flush && (count_q < DEPTH_C) && (drop_cnt_q == '0);
  assign imem_req_valid = issue;
  assign imem_req_addr  = pc_in;
  assign pc_ready       = issue && imem_req_ready && !rst;

  assign push    = pc_ready;
  assign fill_en = imem_resp_valid && !flush && (drop_cnt_q == '0);
  assign if_valid = (count_q != '0) && head_filled;
  assign pop     = if_valid && id_ready && !flush;

  // alloc == fill is ambiguous: either nothing is outstanding or every entry
  // is allocated and waiting. The filled bit at fill tells them apart.
  always_comb begin
    inflight = '0;
    if (alloc_ptr != fill_ptr) begin
      inflight = {1'b0, PW'(alloc_ptr - fill_ptr)};
    end else if (count_q == DEPTH_C && !fill_slot_filled) begin
      inflight = DEPTH_C;
    end
  end

  always_comb begin
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      count_d    = '0;
      drop_cnt_d = drop_cnt_q + inflight - CW'(imem_resp_valid);
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (imem_resp_valid && drop_cnt_q != '0) begin
        drop_cnt_d = drop_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  if_ring_buf #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .push             (push),
    .push_pc          (pc_in),
    .fill_en          (fill_en),
    .fill_inst        (imem_resp_data),
    .pop              (pop),
    .head_pc          (if_pc),
    .head_inst        (if_inst),
    .head_filled      (head_filled),
    .alloc_ptr        (alloc_ptr),
    .fill_ptr         (fill_ptr),
    .fill_slot_filled (fill_slot_filled)
  );

  a_resp_has_owner : assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> ((drop_cnt_q + inflight) != '0));

  a_occupancy : assert property (@(posedge clk) disable iff (rst)
    (drop_cnt_q + count_q) <= DEPTH_C);

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pc_in;
  logic            pc_valid;
  logic            pc_ready;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            flush;
  logic            id_ready;
  logic            if_valid;
  logic [XLEN-1:0] if_inst;
  logic [XLEN-1:0] if_pc;

  if_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_in           (pc_in),
    .pc_valid        (pc_valid),
    .pc_ready        (pc_ready),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .flush           (flush),
    .id_ready        (id_ready),
    .if_valid        (if_valid),
    .if_inst         (if_inst),
    .if_pc           (if_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          filled;
  } ent_t;

  ent_t        exp_q[$];   // allocated, not yet popped (scoreboard)
  logic [31:0] pend_q[$];  // addresses the memory still owes a response for
  int          mdrop;      // responses owed that belong to flushed fetches
  logic [31:0] next_pc;
  int          n_vec;
  int          n_fail;

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return 32'h0050_0093 ^ (a << 12);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance
  // the model, then move to just after the next rising edge.
  task automatic step(input bit pv, input bit rr, input bit re, input bit idr, input bit fl);
    bit resp;
    bit exp_rdy;
    bit exp_vld;
    bit done;
    pc_valid       = pv;
    pc_in          = next_pc;
    imem_req_ready = rr;
    id_ready       = idr;
    flush          = fl;
    resp           = re && (pend_q.size() > 0);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_of(pend_q[0]) : 32'h0;
    if (resp) void'(pend_q.pop_front());
    #1;
    if (rst) begin
      chk("pc_ready_in_rst", {31'b0, pc_ready}, 32'd0);
      exp_q.delete();
      pend_q.delete();
      mdrop = 0;
    end else begin
      exp_rdy = pv && rr && !fl && (exp_q.size() < DEPTH) && (mdrop == 0);
      chk("pc_ready", {31'b0, pc_ready}, {31'b0, exp_rdy});
      chk("req_valid", {31'b0, imem_req_valid},
          {31'b0, pv && !fl && (exp_q.size() < DEPTH) && (mdrop == 0)});
      if (imem_req_valid) chk("req_addr", imem_req_addr, next_pc);
      exp_vld = (exp_q.size() > 0) && exp_q[0].filled;
      chk("if_valid", {31'b0, if_valid}, {31'b0, exp_vld});
      if (exp_vld) begin
        chk("if_pc", if_pc, exp_q[0].pc);
        chk("if_inst", if_inst, exp_q[0].inst);
      end
      chk("count", 32'(dut.count_q), exp_q.size());
      chk("drop_cnt", 32'(dut.drop_cnt_q), mdrop);
      if (fl) begin
        exp_q.delete();
        mdrop = pend_q.size();
      end else begin
        if (exp_vld && idr) void'(exp_q.pop_front());
        if (resp) begin
          if (mdrop > 0) begin
            mdrop--;
          end else begin
            done = 1'b0;
            for (int i = 0; i < exp_q.size(); i++) begin
              if (!done && !exp_q[i].filled) begin
                exp_q[i].filled = 1'b1;
                done = 1'b1;
              end
            end
          end
        end
        if (exp_rdy) begin
          exp_q.push_back('{next_pc, mem_of(next_pc), 1'b0});
          pend_q.push_back(next_pc);
          next_pc = next_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while (((exp_q.size() > 0) || (pend_q.size() > 0)) && (c < maxc)) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      c++;
    end
    chk("drain_count", 32'(dut.count_q), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec  = 0;
    n_fail = 0;
    mdrop  = 0;
    next_pc = 32'h0;
    rst = 1'b1;
    pc_valid = 1'b0; pc_in = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; flush = 1'b0; id_ready = 1'b0;
    @(posedge clk);
    #1;

    // 1: reset, then a single fetch with best-case latency
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    pc_valid = 1'b0;
    #1;
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_pc_ready", {31'b0, pc_ready}, 32'd0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    next_pc = 32'h0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_if_valid", {31'b0, if_valid}, 32'd1);
    chk("t1_if_inst", if_inst, 32'h0050_0093);
    chk("t1_if_pc", if_pc, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // 2: fill to full under decode stall, then release
    next_pc = 32'h0;
    repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_full_pc_ready", {31'b0, pc_ready}, 32'd0);
    repeat (8) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drain(40);

    // 3: random request/response stalls and decode backpressure
    next_pc = 32'h100;
    for (int k = 0; k < 80; k++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, 1'b0);
    end
    drain(60);

    // 4: flush with two in flight while one of them returns
    next_pc = 32'h200;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t4_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
    next_pc = 32'h40;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_if_valid", {31'b0, if_valid}, 32'd1);
    chk("t4_if_pc", if_pc, 32'h40);
    chk("t4_if_inst", if_inst, mem_of(32'h40));
    drain(20);

    // 5: full queue, decode ready, flush in the same cycle
    next_pc = 32'h300;
    repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5_count", 32'(dut.count_q), 32'd0);
    chk("t5_if_valid", {31'b0, if_valid}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // 6: reset mid-stream with two in flight
    next_pc = 32'h400;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    chk("t6_count", 32'(dut.count_q), 32'd0);
    chk("t6_drop_cnt", 32'(dut.drop_cnt_q), 32'd0);
    chk("t6_if_valid", {31'b0, if_valid}, 32'd0);
    chk("t6_if_pc", if_pc, 32'd0);
    next_pc = 32'h500;
    repeat (4) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
